// File: rtl/id_stage.sv
// id_stage: RV32I integer decode stage (OP-IMM, OP, LUI, AUIPC).
// The instruction arrives on a valid/ready handshake and is decoded against
// combinational register-file reads. A load-use hazard on a source that is
// actually read stalls acceptance. The result is held in a one-entry output
// register that is refilled in the same cycle it drains. flush_i drops the
// held result and the incoming beat.
// Optional feature: define ID_BYPASS_EN to add EX/MEM result forwarding
// into the source operands. The default build reads register-file data only.
module id_stage #(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    // upstream handshake
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [31:0]          inst_i,
    // register file read ports
    output logic [NREG_BITS-1:0] reg1_addr_o,
    output logic [NREG_BITS-1:0] reg2_addr_o,
    output logic                 reg1_read_o,
    output logic                 reg2_read_o,
    input  logic [XLEN-1:0]      reg1_data_i,
    input  logic [XLEN-1:0]      reg2_data_i,
    // load currently in EX
    input  logic                 ex_load_i,
    input  logic [NREG_BITS-1:0] ex_wd_i,
`ifdef ID_BYPASS_EN
    // results in flight, forwarded into the operands
    input  logic                 ex_wreg_i,
    input  logic [NREG_BITS-1:0] ex_wd_i2,
    input  logic [XLEN-1:0]      ex_wdata_i,
    input  logic                 mem_wreg_i,
    input  logic [NREG_BITS-1:0] mem_wd_i,
    input  logic [XLEN-1:0]      mem_wdata_i,
`endif
    input  logic                 flush_i,
    // downstream handshake and decoded instruction
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           aluop_o,
    output logic [2:0]           alusel_o,
    output logic [XLEN-1:0]      reg1_o,
    output logic [XLEN-1:0]      reg2_o,
    output logic [NREG_BITS-1:0] wd_o,
    output logic                 wreg_o,
    output logic [XLEN-1:0]      pc_o,
    output logic                 illegal_o
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [7:0] ALU_NOP  = 8'h00;
    localparam logic [7:0] ALU_ADD  = 8'h01;
    localparam logic [7:0] ALU_SUB  = 8'h02;
    localparam logic [7:0] ALU_SLT  = 8'h03;
    localparam logic [7:0] ALU_SLTU = 8'h04;
    localparam logic [7:0] ALU_XOR  = 8'h05;
    localparam logic [7:0] ALU_OR   = 8'h06;
    localparam logic [7:0] ALU_AND  = 8'h07;
    localparam logic [7:0] ALU_SLL  = 8'h08;
    localparam logic [7:0] ALU_SRL  = 8'h09;
    localparam logic [7:0] ALU_SRA  = 8'h0A;

    localparam logic [2:0] SEL_NOP   = 3'd0;
    localparam logic [2:0] SEL_ARITH = 3'd1;
    localparam logic [2:0] SEL_LOGIC = 3'd2;
    localparam logic [2:0] SEL_SHIFT = 3'd3;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        SRC1_ZERO,
        SRC1_REG,
        SRC1_PC
    } src1_e;

    // instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_sh;
    logic [XLEN-1:0] imm_u;
    assign imm_i  = XLEN'($signed(inst_i[31:20]));
    assign imm_sh = XLEN'(inst_i[24:20]);
    assign imm_u  = XLEN'($signed({inst_i[31:12], 12'b0}));

    assign reg1_addr_o = NREG_BITS'(inst_i[19:15]);
    assign reg2_addr_o = NREG_BITS'(inst_i[24:20]);

    // decode results
    logic [7:0]      aluop_d;
    logic [2:0]      alusel_d;
    logic            illegal_d;
    logic            wr_en;
    logic            rd1_en;
    logic            rd2_en;
    logic            use_imm;
    logic [XLEN-1:0] imm_sel;
    src1_e           src1_sel;

    // Opcode/funct decode; any unsupported encoding becomes an illegal NOP.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statements leaves one unassigned (that would infer a latch).
        aluop_d   = ALU_NOP;
        alusel_d  = SEL_NOP;
        illegal_d = 1'b1;
        wr_en     = 1'b0;
        rd1_en    = 1'b0;
        rd2_en    = 1'b0;
        use_imm   = 1'b0;
        imm_sel   = '0;
        src1_sel  = SRC1_ZERO;
        unique case (opcode)
            OPC_OP_IMM: begin
                illegal_d = 1'b0;
                wr_en     = 1'b1;
                rd1_en    = 1'b1;
                use_imm   = 1'b1;
                imm_sel   = imm_i;
                src1_sel  = SRC1_REG;
                unique case (funct3)
                    3'b000: begin aluop_d = ALU_ADD;  alusel_d = SEL_ARITH; end
                    3'b010: begin aluop_d = ALU_SLT;  alusel_d = SEL_ARITH; end
                    3'b011: begin aluop_d = ALU_SLTU; alusel_d = SEL_ARITH; end
                    3'b100: begin aluop_d = ALU_XOR;  alusel_d = SEL_LOGIC; end
                    3'b110: begin aluop_d = ALU_OR;   alusel_d = SEL_LOGIC; end
                    3'b111: begin aluop_d = ALU_AND;  alusel_d = SEL_LOGIC; end
                    3'b001: begin
                        imm_sel   = imm_sh;
                        aluop_d   = ALU_SLL;
                        alusel_d  = SEL_SHIFT;
                        illegal_d = (funct7 != F7_BASE);
                    end
                    default: begin
                        imm_sel   = imm_sh;
                        alusel_d  = SEL_SHIFT;
                        aluop_d   = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        illegal_d = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                illegal_d = 1'b0;
                wr_en     = 1'b1;
                rd1_en    = 1'b1;
                rd2_en    = 1'b1;
                src1_sel  = SRC1_REG;
                if (funct7 == F7_BASE) begin
                    unique case (funct3)
                        3'b000: begin aluop_d = ALU_ADD;  alusel_d = SEL_ARITH; end
                        3'b001: begin aluop_d = ALU_SLL;  alusel_d = SEL_SHIFT; end
                        3'b010: begin aluop_d = ALU_SLT;  alusel_d = SEL_ARITH; end
                        3'b011: begin aluop_d = ALU_SLTU; alusel_d = SEL_ARITH; end
                        3'b100: begin aluop_d = ALU_XOR;  alusel_d = SEL_LOGIC; end
                        3'b101: begin aluop_d = ALU_SRL;  alusel_d = SEL_SHIFT; end
                        3'b110: begin aluop_d = ALU_OR;   alusel_d = SEL_LOGIC; end
                        default: begin aluop_d = ALU_AND; alusel_d = SEL_LOGIC; end
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    aluop_d  = ALU_SUB;
                    alusel_d = SEL_ARITH;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    aluop_d  = ALU_SRA;
                    alusel_d = SEL_SHIFT;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                illegal_d = 1'b0;
                wr_en     = 1'b1;
                use_imm   = 1'b1;
                imm_sel   = imm_u;
                aluop_d   = ALU_ADD;
                alusel_d  = SEL_ARITH;
                src1_sel  = (opcode == OPC_AUIPC) ? SRC1_PC : SRC1_ZERO;
            end
            default: ;
        endcase
        // an illegal instruction reads nothing, writes nothing, executes a NOP
        if (illegal_d) begin
            aluop_d  = ALU_NOP;
            alusel_d = SEL_NOP;
            wr_en    = 1'b0;
            rd1_en   = 1'b0;
            rd2_en   = 1'b0;
            use_imm  = 1'b0;
            src1_sel = SRC1_ZERO;
        end
    end

    assign reg1_read_o = rd1_en;
    assign reg2_read_o = rd2_en;

    // source operand values: x0 is hard zero, otherwise forwarded or regfile
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // Source 1 value, youngest producer first.
    always_comb begin
        rs1_val = reg1_data_i;
`ifdef ID_BYPASS_EN
        if (ex_wreg_i && ex_wd_i2 == reg1_addr_o) begin
            rs1_val = ex_wdata_i;
        end else if (mem_wreg_i && mem_wd_i == reg1_addr_o) begin
            rs1_val = mem_wdata_i;
        end
`endif
        if (reg1_addr_o == '0) begin
            rs1_val = '0;
        end
    end

    // Source 2 value, youngest producer first.
    always_comb begin
        rs2_val = reg2_data_i;
`ifdef ID_BYPASS_EN
        if (ex_wreg_i && ex_wd_i2 == reg2_addr_o) begin
            rs2_val = ex_wdata_i;
        end else if (mem_wreg_i && mem_wd_i == reg2_addr_o) begin
            rs2_val = mem_wdata_i;
        end
`endif
        if (reg2_addr_o == '0) begin
            rs2_val = '0;
        end
    end

    // next-state values for the output register
    logic [XLEN-1:0]      reg1_d;
    logic [XLEN-1:0]      reg2_d;
    logic [NREG_BITS-1:0] wd_d;
    logic                 wreg_d;

    // Operand 1 source select and the remaining output fields.
    always_comb begin
        unique case (src1_sel)
            SRC1_REG: reg1_d = rd1_en ? rs1_val : '0;
            SRC1_PC:  reg1_d = pc_i;
            default:  reg1_d = '0;
        endcase
        reg2_d = use_imm ? imm_sel : (rd2_en ? rs2_val : '0);
        wd_d   = illegal_d ? '0 : NREG_BITS'(rd);
        wreg_d = wr_en && (rd != 5'd0);
    end

    // load-use hazard: only a source the instruction really reads counts
    logic stall;
    logic load;
    assign stall = ex_load_i && (ex_wd_i != '0) &&
                   ((rd1_en && ex_wd_i == reg1_addr_o) ||
                    (rd2_en && ex_wd_i == reg2_addr_o));

    logic                 out_valid_q;
    logic [7:0]           aluop_q;
    logic [2:0]           alusel_q;
    logic [XLEN-1:0]      reg1_q;
    logic [XLEN-1:0]      reg2_q;
    logic [NREG_BITS-1:0] wd_q;
    logic                 wreg_q;
    logic [XLEN-1:0]      pc_q;
    logic                 illegal_q;

    assign in_ready = !stall && (!out_valid_q || out_ready);
    // a flushed beat is consumed from upstream but never loaded
    assign load     = in_valid && in_ready && !flush_i;

    // One-entry output register: flush drops, accept loads, handshake drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            aluop_q     <= ALU_NOP;
            alusel_q    <= SEL_NOP;
            reg1_q      <= '0;
            reg2_q      <= '0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            pc_q        <= '0;
            illegal_q   <= 1'b0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            out_valid_q <= 1'b1;
            aluop_q     <= aluop_d;
            alusel_q    <= alusel_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            pc_q        <= pc_i;
            illegal_q   <= illegal_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign aluop_o   = aluop_q;
    assign alusel_o  = alusel_q;
    assign reg1_o    = reg1_q;
    assign reg2_o    = reg2_q;
    assign wd_o      = wd_q;
    assign wreg_o    = wreg_q;
    assign pc_o      = pc_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: self-checking bench for id_stage. Table-driven decode vectors
// plus hand-written sequences for stall, back-pressure, flush and reset.
// Decoded results go through a scoreboard queue: pushed on accept, popped
// and compared on each downstream handshake. With ID_BYPASS_EN defined the
// forwarding ports are connected and exercised.
module tb_id_stage;

    localparam int XLEN = 32;
    localparam int NB   = 5;

    localparam logic [7:0] A_NOP  = 8'h00;
    localparam logic [7:0] A_ADD  = 8'h01;
    localparam logic [7:0] A_SUB  = 8'h02;
    localparam logic [7:0] A_SLT  = 8'h03;
    localparam logic [7:0] A_SLTU = 8'h04;
    localparam logic [7:0] A_XOR  = 8'h05;
    localparam logic [7:0] A_OR   = 8'h06;
    localparam logic [7:0] A_AND  = 8'h07;
    localparam logic [7:0] A_SLL  = 8'h08;
    localparam logic [7:0] A_SRL  = 8'h09;
    localparam logic [7:0] A_SRA  = 8'h0A;
    localparam logic [2:0] S_NOP  = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_LG   = 3'd2;
    localparam logic [2:0] S_SH   = 3'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid, in_ready, out_valid, out_ready, flush_i;
    logic [XLEN-1:0] pc_i;
    logic [31:0] inst_i;
    logic [NB-1:0] reg1_addr_o, reg2_addr_o, ex_wd_i, wd_o;
    logic reg1_read_o, reg2_read_o, ex_load_i, wreg_o, illegal_o;
    logic [XLEN-1:0] reg1_data_i, reg2_data_i, reg1_o, reg2_o, pc_o;
    logic [7:0] aluop_o;
    logic [2:0] alusel_o;
`ifdef ID_BYPASS_EN
    logic ex_wreg_i, mem_wreg_i;
    logic [NB-1:0] ex_wd_i2, mem_wd_i;
    logic [XLEN-1:0] ex_wdata_i, mem_wdata_i;
`endif

    always #5 clk = ~clk;

    logic [31:0] rf [32];
    assign reg1_data_i = rf[reg1_addr_o];
    assign reg2_data_i = rf[reg2_addr_o];

    id_stage #(.XLEN(XLEN), .NREG_BITS(NB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i), .inst_i(inst_i),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_load_i(ex_load_i), .ex_wd_i(ex_wd_i),
`ifdef ID_BYPASS_EN
        .ex_wreg_i(ex_wreg_i), .ex_wd_i2(ex_wd_i2), .ex_wdata_i(ex_wdata_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
`endif
        .flush_i(flush_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o), .illegal_o(illegal_o)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic        illegal;
    } vec_t;

    vec_t sb[$];
    vec_t cur;
    vec_t tbl[18];
    int checks = 0;
    int failures = 0;
    logic bp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [31:0] inst, logic [31:0] pc, logic [7:0] aluop,
                                logic [2:0] alusel, logic [31:0] reg1, logic [31:0] reg2,
                                logic [4:0] wd, logic wreg, logic illegal);
        vec_t v;
        v.inst = inst; v.pc = pc; v.aluop = aluop; v.alusel = alusel;
        v.reg1 = reg1; v.reg2 = reg2; v.wd = wd; v.wreg = wreg; v.illegal = illegal;
        return v;
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
        return {imm, rd, op};
    endfunction

    task automatic cmp_out(input vec_t e);
        check($sformatf("aluop[%08h]", e.inst), aluop_o, e.aluop);
        check($sformatf("alusel[%08h]", e.inst), alusel_o, e.alusel);
        check($sformatf("reg1[%08h]", e.inst), reg1_o, e.reg1);
        check($sformatf("reg2[%08h]", e.inst), reg2_o, e.reg2);
        check($sformatf("wd[%08h]", e.inst), wd_o, e.wd);
        check($sformatf("wreg[%08h]", e.inst), wreg_o, e.wreg);
        check($sformatf("illegal[%08h]", e.inst), illegal_o, e.illegal);
        check($sformatf("pc[%08h]", e.inst), pc_o, e.pc);
    endtask

    // monitor: mid-cycle sampling of both handshakes and of held outputs
    logic hold_pending = 1'b0;
    logic [7:0] h_aluop;
    logic [31:0] h_reg1, h_reg2, h_pc;
    logic [6:0] h_misc;
    always @(negedge clk) begin
        if (rst) begin
            if (hold_pending) begin
                check("hold_valid", out_valid, 1);
                check("hold_aluop", aluop_o, h_aluop);
                check("hold_reg1", reg1_o, h_reg1);
                check("hold_reg2", reg2_o, h_reg2);
                check("hold_pc", pc_o, h_pc);
                check("hold_misc", {wd_o, wreg_o, illegal_o}, h_misc);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: output beat %08h with empty scoreboard", pc_o);
                end else begin
                    cmp_out(sb.pop_front());
                end
            end
            if (in_valid && in_ready && !flush_i) sb.push_back(cur);
            hold_pending = out_valid && !out_ready && !flush_i;
            h_aluop = aluop_o; h_reg1 = reg1_o; h_reg2 = reg2_o; h_pc = pc_o;
            h_misc = {wd_o, wreg_o, illegal_o};
        end else begin
            hold_pending = 1'b0;
        end
    end

    // drive a vector without waiting (inputs change just after a rising edge)
    task automatic apply(input vec_t v);
        cur = v;
        inst_i = v.inst;
        pc_i = v.pc;
        in_valid = 1'b1;
    endtask

    // drive a vector and wait, bounded, until it is accepted
    task automatic send(input vec_t v);
        bit ok = 1'b0;
        apply(v);
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready && !flush_i && rst) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: inst %08h never accepted", v.inst);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && (sb.size() != 0 || out_valid); n++) begin
            @(posedge clk);
            #1;
        end
        check("drain_sb_empty", sb.size(), 0);
        check("drain_out_valid", out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t va, vb, vc;
        in_valid = 0; out_ready = 0; flush_i = 0; ex_load_i = 0; ex_wd_i = 0;
        inst_i = 0; pc_i = 0;
`ifdef ID_BYPASS_EN
        ex_wreg_i = 0; ex_wd_i2 = 0; ex_wdata_i = 0;
        mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
`endif
        for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 | 32'(i);
        rf[2] = 32'h0000_00F0;

        tbl[0]  = mk(enc_i(12'hFFF, 2, 3'd6, 1), 32'h1000, A_OR, S_LG, 32'hF0, 32'hFFFF_FFFF, 1, 1, 0);
        tbl[1]  = mk(enc_i(12'hFFE, 3, 3'd0, 5), 32'h1004, A_ADD, S_AR, 32'hA000_0003, 32'hFFFF_FFFE, 5, 1, 0);
        tbl[2]  = mk(enc_i(12'h7FF, 7, 3'd3, 6), 32'h1008, A_SLTU, S_AR, 32'hA000_0007, 32'h7FF, 6, 1, 0);
        tbl[3]  = mk(enc_i(12'h41F, 9, 3'd5, 8), 32'h100C, A_SRA, S_SH, 32'hA000_0009, 32'd31, 8, 1, 0);
        tbl[4]  = mk(enc_i(12'h003, 11, 3'd1, 10), 32'h1010, A_SLL, S_SH, 32'hA000_000B, 32'd3, 10, 1, 0);
        tbl[5]  = mk(enc_r(7'h20, 14, 13, 3'd0, 12), 32'h1014, A_SUB, S_AR, 32'hA000_000D, 32'hA000_000E, 12, 1, 0);
        tbl[6]  = mk(enc_r(7'h00, 16, 0, 3'd3, 15), 32'h1018, A_SLTU, S_AR, 32'h0, 32'hA000_0010, 15, 1, 0);
        tbl[7]  = mk(enc_r(7'h20, 19, 18, 3'd5, 17), 32'h101C, A_SRA, S_SH, 32'hA000_0012, 32'hA000_0013, 17, 1, 0);
        tbl[8]  = mk(enc_r(7'h00, 22, 21, 3'd7, 20), 32'h1020, A_AND, S_LG, 32'hA000_0015, 32'hA000_0016, 20, 1, 0);
        tbl[9]  = mk(enc_u(20'h80001, 23, 7'h37), 32'h1024, A_ADD, S_AR, 32'h0, 32'h8000_1000, 23, 1, 0);
        tbl[10] = mk(enc_u(20'h00010, 24, 7'h17), 32'h4000, A_ADD, S_AR, 32'h4000, 32'h0001_0000, 24, 1, 0);
        tbl[11] = mk(enc_u(20'h12345, 0, 7'h37), 32'h102C, A_ADD, S_AR, 32'h0, 32'h1234_5000, 0, 0, 0);
        tbl[12] = mk(32'h0000_0FFF, 32'h1030, A_NOP, S_NOP, 32'h0, 32'h0, 0, 0, 1);
        tbl[13] = mk(enc_r(7'h01, 2, 1, 3'd0, 3), 32'h1034, A_NOP, S_NOP, 32'h0, 32'h0, 0, 0, 1);
        tbl[14] = mk(enc_i(12'h403, 11, 3'd1, 10), 32'h1038, A_NOP, S_NOP, 32'h0, 32'h0, 0, 0, 1);
        tbl[15] = mk(enc_r(7'h00, 3, 2, 3'd2, 1), 32'h103C, A_SLT, S_AR, 32'hF0, 32'hA000_0003, 1, 1, 0);
        tbl[16] = mk(enc_i(12'h004, 2, 3'd5, 1), 32'h1040, A_SRL, S_SH, 32'hF0, 32'd4, 1, 1, 0);
        tbl[17] = mk(enc_i(12'h800, 4, 3'd4, 3), 32'h1044, A_XOR, S_LG, 32'hA000_0004, 32'hFFFF_F800, 3, 1, 0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_aluop", aluop_o, A_NOP);
        check("rst_alusel", alusel_o, S_NOP);
        check("rst_reg1", reg1_o, 0);
        check("rst_reg2", reg2_o, 0);
        check("rst_wd", wd_o, 0);
        check("rst_wreg", wreg_o, 0);
        check("rst_pc", pc_o, 0);
        check("rst_illegal", illegal_o, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ORI latency: valid exactly one edge after accept
        out_ready = 1'b1;
        apply(tbl[0]);
        check("lat_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check("lat_out_valid", out_valid, 1);
        in_valid = 1'b0;
        drain();

        // decode table with random back-pressure
        bp_en = 1'b1;
        fork
            begin
                while (bp_en) begin
                    @(posedge clk);
                    #1;
                    if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 18; i++) send(tbl[i]);
        in_valid = 1'b0;
        bp_en = 1'b0;
        out_ready = 1'b1;
        drain();

        // load-use stall on rs1, then accepted once the load leaves EX
        va = mk(enc_r(7'h00, 5, 3, 3'd0, 4), 32'h2000, A_ADD, S_AR, 32'hA000_0003, 32'hA000_0005, 4, 1, 0);
        ex_load_i = 1'b1;
        ex_wd_i = 5'd3;
        apply(va);
        #1;
        check("stall_rs1_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        check("stall_out_valid", out_valid, 0);
        ex_load_i = 1'b0;
        #1;
        check("stall_release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check("stall_release_out_valid", out_valid, 1);
        in_valid = 1'b0;
        drain();
        // stall on rs2
        ex_load_i = 1'b1;
        ex_wd_i = 5'd5;
        apply(va);
        #1;
        check("stall_rs2_in_ready", in_ready, 0);
        in_valid = 1'b0;
        // imm[4:0] matches but rs2 is not read by an I-type
        vb = mk(enc_i(12'h005, 3, 3'd0, 4), 32'h2004, A_ADD, S_AR, 32'hA000_0003, 32'd5, 4, 1, 0);
        apply(vb);
        #1;
        check("nostall_unread_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        // load to x0 never stalls
        ex_wd_i = 5'd0;
        vc = mk(enc_r(7'h00, 5, 0, 3'd0, 4), 32'h2008, A_ADD, S_AR, 32'h0, 32'hA000_0005, 4, 1, 0);
        apply(vc);
        #1;
        check("nostall_x0_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ex_load_i = 1'b0;
        drain();

        // three ADDI back to back, downstream stalls after the first
        va = mk(enc_i(12'h011, 1, 3'd0, 6), 32'h3000, A_ADD, S_AR, 32'hA000_0001, 32'h11, 6, 1, 0);
        vb = mk(enc_i(12'h022, 2, 3'd0, 7), 32'h3004, A_ADD, S_AR, 32'hF0, 32'h22, 7, 1, 0);
        vc = mk(enc_i(12'h033, 3, 3'd0, 8), 32'h3008, A_ADD, S_AR, 32'hA000_0003, 32'h33, 8, 1, 0);
        out_ready = 1'b1;
        send(va);
        out_ready = 1'b0;
        fork
            begin
                send(vb);
                send(vc);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        drain();

        // flush with a held result and an incoming beat, downstream stalled
        out_ready = 1'b0;
        send(va);
        apply(vb);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        in_valid = 1'b0;
        check("flush_held_out_valid", out_valid, 0);
        check("flush_held_sb", sb.size(), 1);
        if (sb.size() != 0) void'(sb.pop_front());
        @(posedge clk);
        #1;
        check("flush_held_dropped", out_valid, 0);
        // flush with downstream ready: incoming beat still dropped
        out_ready = 1'b1;
        send(va);
        apply(vb);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        in_valid = 1'b0;
        check("flush_rdy_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("flush_rdy_dropped", out_valid, 0);
        drain();

`ifdef ID_BYPASS_EN
        // EX beats MEM for the same register; x0 never forwarded
        ex_wreg_i = 1; ex_wd_i2 = 5'd2; ex_wdata_i = 32'hAA;
        mem_wreg_i = 1; mem_wd_i = 5'd2; mem_wdata_i = 32'hBB;
        send(mk(enc_i(12'h001, 2, 3'd0, 1), 32'h5000, A_ADD, S_AR, 32'hAA, 32'h1, 1, 1, 0));
        ex_wreg_i = 0;
        send(mk(enc_i(12'h001, 2, 3'd0, 1), 32'h5004, A_ADD, S_AR, 32'hBB, 32'h1, 1, 1, 0));
        ex_wreg_i = 1; ex_wd_i2 = 5'd3;
        send(mk(enc_r(7'h00, 2, 3, 3'd0, 5), 32'h5008, A_ADD, S_AR, 32'hAA, 32'hBB, 5, 1, 0));
        ex_wd_i2 = 5'd0; mem_wd_i = 5'd0;
        send(mk(enc_i(12'h001, 0, 3'd0, 1), 32'h500C, A_ADD, S_AR, 32'h0, 32'h1, 1, 1, 0));
        in_valid = 1'b0;
        ex_wreg_i = 0; mem_wreg_i = 0;
        drain();
`endif

        // asynchronous reset mid-stream, then first beat after release
        out_ready = 1'b0;
        send(vc);
        apply(va);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_aluop", aluop_o, A_NOP);
        check("arst_alusel", alusel_o, S_NOP);
        check("arst_reg1", reg1_o, 0);
        check("arst_reg2", reg2_o, 0);
        check("arst_wd", wd_o, 0);
        check("arst_wreg", wreg_o, 0);
        check("arst_pc", pc_o, 0);
        check("arst_illegal", illegal_o, 0);
        sb.delete();
        @(posedge clk);
        #1;
        check("arst_held_out_valid", out_valid, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_release_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("arst_first_beat", out_valid, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        check("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/register width.
REQ-002 SHALL have parameter NREG_BITS, default 5, register-address width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1: upstream handshake carrying pc_i input XLEN and inst_i input 32.
REQ-006 SHALL have ports reg1_addr_o, reg2_addr_o output NREG_BITS; reg1_read_o, reg2_read_o output 1; reg1_data_i, reg2_data_i input XLEN (combinational regfile reads).
REQ-007 SHALL have ports ex_load_i input 1, ex_wd_i input NREG_BITS: load in EX and its destination.
REQ-008 SHALL have port flush_i input 1: discard held and incoming instruction.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1: downstream handshake.
REQ-010 SHALL have registered outputs aluop_o 8, alusel_o 3, reg1_o XLEN, reg2_o XLEN, wd_o NREG_BITS, wreg_o 1, pc_o XLEN, illegal_o 1.

Function
REQ-011 SHALL decode OP-IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI), OP (all 10 RV32I R-type), LUI, AUIPC; any other opcode or funct7 sets illegal_o=1, wreg_o=0, aluop NOP.
REQ-012 SHALL sign-extend I-type immediates to XLEN; shift immediates use inst[24:20] zero-extended; LUI/AUIPC use inst[31:12]<<12 sign-extended to XLEN.
REQ-013 SHALL drive reg1_o = rs1 data (AUIPC: pc_i; LUI: 0) and reg2_o = rs2 data for OP, immediate otherwise.
REQ-014 SHALL read x0 as 0 regardless of reg*_data_i; wreg_o=0 when rd=x0.
REQ-015 SHALL hold a one-entry output register: load when in_valid && in_ready; out_valid clears when out_ready && out_valid and no new load.
REQ-016 SHALL assert in_ready = !stall && (!out_valid || out_ready) (pass-through, zero bubble throughput).
REQ-017 SHALL assert stall when ex_load_i && ex_wd_i!=0 && ex_wd_i equals a source register actually read by inst_i; stalled instruction not accepted.
REQ-018 SHALL have decode latency exactly 1 cycle from accept to out_valid.
REQ-019 SHALL, while out_valid && !out_ready, hold every output stable.
REQ-020 SHALL, on flush_i, clear out_valid next edge and accept nothing that cycle; flush overrides stall and accept.

Reset
REQ-021 SHALL, while rst=0, clear out_valid, illegal_o, wreg_o to 0, aluop_o/alusel_o to NOP, reg1_o, reg2_o, pc_o, wd_o to 0, independent of clk.
REQ-022 SHALL, on rst deassertion mid-stream, accept the first in_valid beat no earlier than the next rising edge.

Configuration
REQ-023 SHALL, with ID_BYPASS_EN defined, add inputs ex_wreg_i, ex_wd_i2, ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i and forward into reg1_o/reg2_o, EX priority over MEM, never for x0.
REQ-024 SHALL, without ID_BYPASS_EN, omit those ports and use regfile data only.

Verification
REQ-025 ORI x1,x2,0xFFF with x2=0x0000_00F0 -> 1 cycle later out_valid=1, aluop OR, reg1_o=0xF0, reg2_o=0xFFFF_FFFF, wd_o=1, wreg_o=1.
REQ-026 ex_load_i=1, ex_wd_i=3, inst ADD x4,x3,x5 -> in_ready=0 that cycle; accepted the cycle after ex_load_i drops.
REQ-027 Three back-to-back ADDI with out_ready held 0 after first -> first held stable, in_ready=0, none lost or duplicated after out_ready=1.
REQ-028 flush_i with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, incoming beat dropped.
REQ-029 opcode 0x7F -> illegal_o=1, wreg_o=0; LUI x0 -> wreg_o=0.
REQ-030 ID_BYPASS_EN, EX and MEM both writing x2 (0xAA, 0xBB), ADDI x1,x2,1 -> reg1_o=0xAA; rst pulsed low mid-stream -> all outputs at reset values immediately.
